// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multichannel PWM generator.
package pwm_pkg;

  localparam int unsigned DEF_PERIOD    = 10;
  localparam int unsigned DEF_STEP      = 1;
  localparam int unsigned DEF_INIT_DUTY = 5;
  localparam int unsigned DEB_DIV_FPGA  = 25000000;
  localparam int unsigned DEB_DIV_SIM   = 4;

  // Smallest width able to hold v distinct values (ceil(log2(v))).
  function automatic int unsigned pwm_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Saturating duty step; inc and dec together cancel.
  function automatic int unsigned sat_step(input int unsigned duty,
                                           input int unsigned step,
                                           input int unsigned limit,
                                           input logic        inc,
                                           input logic        dec);
    if (inc && !dec) return (duty + step > limit) ? limit : duty + step;
    if (dec && !inc) return (duty < step) ? 0 : duty - step;
    return duty;
  endfunction

endpackage

// File: rtl/pwm_button_debounce.sv
// Two-flop push-button sampler that yields one press pulse per press.
module pwm_button_debounce
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic press_pulse
);

  logic q1, q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else if (tick) begin
      q1 <= raw;
      q2 <= q1;
    end
  end

  assign press_pulse = q1 & ~q2 & tick;

endmodule

// File: rtl/pwm_multichannel_generator.sv
// N-channel PWM with shared period counter and per-channel button-driven duty.
module pwm_multichannel_generator
  import pwm_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 2,
  parameter  int unsigned PERIOD    = DEF_PERIOD,
  parameter  int unsigned STEP      = DEF_STEP,
  parameter  int unsigned INIT_DUTY = DEF_INIT_DUTY,
  parameter  int unsigned DEB_DIV   = DEB_DIV_FPGA,
  localparam int unsigned CW        = pwm_clog2(PERIOD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_CH-1:0]    increase_duty,
  input  logic [NUM_CH-1:0]    decrease_duty,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 period_start,
  output logic [NUM_CH*CW-1:0] duty_level
);

  localparam int unsigned PW = pwm_clog2(DEB_DIV);

  logic [PW-1:0]     deb_cnt;
  logic              tick;
  logic [CW-1:0]     cnt;
  logic              last_cycle;
  logic [NUM_CH-1:0] inc_evt, dec_evt;
  logic [CW-1:0]     shadow [NUM_CH];
  logic [CW-1:0]     active [NUM_CH];

  assign tick       = (deb_cnt == PW'(DEB_DIV - 1));
  assign last_cycle = en && (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       deb_cnt <= '0;
    else if (tick) deb_cnt <= '0;
    else           deb_cnt <= deb_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_btn
    pwm_button_debounce u_inc (
      .clk(clk), .rst(rst), .tick(tick),
      .raw(increase_duty[g]), .press_pulse(inc_evt[g])
    );
    pwm_button_debounce u_dec (
      .clk(clk), .rst(rst), .tick(tick),
      .raw(decrease_duty[g]), .press_pulse(dec_evt[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (last_cycle) cnt <= '0;
    else if (en)         cnt <= cnt + 1'b1;
  end

  // Shadow tracks presses at any time; active only reloads at the period end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= CW'(INIT_DUTY);
        active[i] <= CW'(INIT_DUTY);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= CW'(sat_step(32'(shadow[i]), STEP, PERIOD, inc_evt[i], dec_evt[i]));
        if (last_cycle) active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++)
        pwm_out[i] <= en && (cnt < active[i]);
      period_start <= en && (cnt == '0);
    end
  end

  always_comb begin
    duty_level = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      duty_level[i*CW +: CW] = active[i];
  end

endmodule

// File: doc/pwm_multichannel_generator.md
Name: pwm_multichannel_generator

Overview:
- N-channel PWM generator with a common period counter. Each channel has its own duty register and its own debounced increase/decrease push-button pair.
- Generalises the single-channel fixed-10-step generator:
  - parametrised period, step, channel count and debounce rate;
  - saturating duty arithmetic;
  - glitch-free duty update at period boundaries;
  - global enable and a period-start strobe.
- Sits between board push-buttons / control logic and motor, LED or audio drivers.

Parameters:
- NUM_CH, 2, number of independent PWM channels (>=1).
- PERIOD, 10, PWM period in clk cycles (>=2); f_pwm = f_clk/PERIOD.
- STEP, 1, duty increment/decrement per accepted button press (1..PERIOD).
- INIT_DUTY, 5, duty loaded at reset, all channels (0..PERIOD).
- DEB_DIV, 25000000, clk cycles per debounce sample tick (>=2). Use a small value in simulation.
- CW, derived = clog2(PERIOD+1), width of the counter and duty values.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable. 0 freezes the period counter and forces all outputs low.
- increase_duty  in  NUM_CH  raw (bouncy) increase buttons, one bit per channel.
- decrease_duty  in  NUM_CH  raw decrease buttons, one bit per channel.
- pwm_out  out  NUM_CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse on the cycle where the counter is 0 and en=1.
- duty_level  out  NUM_CH*CW  active duty per channel, channel i at bits [i*CW +: CW].

Behaviour:
- Reset (async assert, sync-free release) sets:
  - debounce prescaler = 0 and all debounce flops = 0;
  - period counter = 0;
  - shadow duty = active duty = INIT_DUTY for every channel;
  - pwm_out = 0, period_start = 0.
- Debounce prescaler:
  - counts 0..DEB_DIV-1 and wraps to 0;
  - `tick` = 1 for exactly one cycle when the count equals DEB_DIV-1;
  - free-running and independent of en.
- Per-button debounce:
  - two flops q1, q2 load only on tick (q1<=raw, q2<=q1);
  - press event = q1 & ~q2 & tick, at most one event per press per tick period;
  - holding a button produces exactly one event.
- Shadow duty update, per channel, on a clk edge with events:
  - inc only: shadow <= min(shadow+STEP, PERIOD). Compute at CW+1 bits, no wrap.
  - dec only: shadow <= max(shadow-STEP, 0). No underflow wrap.
  - inc and dec in the same cycle: no change.
  - Already saturated: no change, no wrap-around.
  - Shadow updates regardless of en.
- Period counter:
  - if en, counts 0..PERIOD-1 and wraps;
  - if en=0, holds its value.
- Active duty:
  - active <= shadow on the cycle where counter==PERIOD-1 and en=1, so it takes effect when the counter returns to 0;
  - never changes mid-period, so no runt pulses.
- Output, 1-cycle registered:
  - pwm_out[i] <= en & (counter < active[i]);
  - active=0 gives constant low; active=PERIOD gives constant high;
  - high time per period = active cycles exactly.
- period_start <= en & (counter==0), registered and aligned with pwm_out.
- duty_level is active duty (combinational from the register).
- en deasserted mid-period:
  - pwm_out goes low on the next edge;
  - counter freezes;
  - on re-enable, the period resumes from the frozen count.
- Reset mid-period: immediate low outputs. After release, the first period starts from counter 0 with INIT_DUTY.

Decomposition:
- Package pwm_pkg holds:
  - the clog2-based CW function;
  - default constants (PERIOD, STEP, INIT_DUTY, sim/FPGA DEB_DIV values);
  - a saturating add/sub function on CW+1 bits.
- One sub-module, pwm_button_debounce (clk, rst, tick, raw -> press_pulse), instantiated 2*NUM_CH times.
- Prescaler, counter, duty registers and compare logic stay in the top module.

Test Plan:
(Setup: NUM_CH=2, PERIOD=10, STEP=1, INIT_DUTY=5, DEB_DIV=4.)
- Reset then en=1, no buttons -> both pwm_out high 5 / low 5 cycles per period; period_start every 10 cycles, aligned with the first high cycle; duty_level=5,5.
- Hold increase_duty[0] for 20 cycles -> exactly one event. Ch0 goes to 6 high cycles starting at the next period boundary; ch1 stays at 5; no partial period in between.
- Seven separate increase presses on ch0 -> duty saturates at 10, pwm_out[0] constantly high. Eleven decrease presses -> saturates at 0, constantly low, never wraps.
- Raw bouncing pattern 1-0-1-0 between ticks on decrease_duty[1] -> at most one decrement; duty_level ch1 = 4.
- Simultaneous inc and dec press on ch0 -> duty unchanged. Drop en mid-period -> outputs low next cycle; counter holds; re-enable resumes from held count.
- Assert rst mid-period with duty 8 -> outputs 0 immediately; after release duty_level=5,5 and the first period_start occurs 1 cycle after en sampled high.
